// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN_REQ,
      ST_DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic fetch_entry_t empty_entry();
      fetch_entry_t e;
      e.valid = 1'b0;
      e.pc    = 32'h0;
      e.instr = NOP_INSTR;
      return e;
   endfunction

endpackage

// File: rtl/if_out_buffer.sv
// IF/ID output register plus one-entry skid; a load lands in the output when it is free this cycle.
// Flush wins over load and consume; while not consumed both entries hold.
module if_out_buffer
   import if_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [31:0]  load_pc_i,
   input  logic [31:0]  load_instr_i,
   input  logic         consume_i,
   input  logic         flush_i,
   output fetch_entry_t out_o,
   output logic         skid_full_o,
   output logic         skid_full_next_o
);

   fetch_entry_t out_q, skid_q, out_d, skid_d, new_e;

   always_comb begin
      new_e.valid = 1'b1;
      new_e.pc    = load_pc_i;
      new_e.instr = load_instr_i;
      out_d       = out_q;
      skid_d      = skid_q;
      if (flush_i) begin
         out_d.valid  = 1'b0;
         skid_d.valid = 1'b0;
      end else begin
         // Consume first so an arriving load sees the freed slot.
         if (consume_i) begin
            out_d        = skid_q;
            skid_d.valid = 1'b0;
         end
         if (load_i) begin
            if (!out_d.valid) begin
               out_d = new_e;
            end else begin
               skid_d = new_e;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q  <= empty_entry();
         skid_q <= empty_entry();
      end else begin
         out_q  <= out_d;
         skid_q <= skid_d;
      end
   end

   assign out_o            = out_q;
   assign skid_full_o      = skid_q.valid;
   assign skid_full_next_o = skid_d.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, response to IF/ID in 2 cycles, 1 instr per 2 cycles peak.
// Stall holds the output and fills the skid, after which fetching pauses; redirect flushes everything.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_instr_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  addr_q;
   logic [31:0]  redirect_tgt;
   logic         load, consume, skid_full, skid_full_next;
   fetch_entry_t out_e;

   assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
   assign consume      = out_e.valid && !stall_i;

   // addr_q tracks the presented address so a stale request survives a redirect unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (state_q == ST_REQ) begin
            addr_q <= fetch_pc_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!skid_full_next) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_i) begin
               state_d = imem_gnt_i ? ST_DRAIN : ST_DRAIN_REQ;
            end else if (imem_gnt_i) begin
               state_d    = ST_WAIT;
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid_i) begin
               state_d = skid_full_next ? ST_IDLE : ST_REQ;
            end else if (redirect_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN_REQ: begin
            if (imem_gnt_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (imem_rvalid_i) state_d = ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect_i) begin
         fetch_pc_d = redirect_tgt;
      end
   end

   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = fetch_pc_q;
      load        = 1'b0;
      case (state_q)
         ST_REQ:       imem_req_o = 1'b1;
         ST_DRAIN_REQ: begin
            imem_req_o  = 1'b1;
            imem_addr_o = addr_q;
         end
         ST_WAIT:      load = imem_rvalid_i && !redirect_i;
         default:      ;
      endcase
      if (rst_i) begin
         imem_req_o = 1'b0;
      end
   end

   if_out_buffer u_out_buffer (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .load_i           (load),
      .load_pc_i        (addr_q),
      .load_instr_i     (imem_rdata_i),
      .consume_i        (consume),
      .flush_i          (redirect_i),
      .out_o            (out_e),
      .skid_full_o      (skid_full),
      .skid_full_next_o (skid_full_next)
   );

   assign if_valid_o = out_e.valid;
   assign if_pc_o    = out_e.valid ? out_e.pc : 32'h0;
   assign if_instr_o = out_e.valid ? out_e.instr : NOP_INSTR;

   a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      !(imem_rvalid_i && (state_q == ST_IDLE || state_q == ST_REQ)));

   a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (imem_req_o && !imem_gnt_i && !redirect_i) |=> (imem_req_o && $stable(imem_addr_o)));

   a_skid_empty_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
      !(state_q == ST_WAIT && skid_full));

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the non-forwarding RV32I pipeline.
- Produces the PC/instruction pair latched by the IF/ID pipeline register and owns the fetch PC.
- Issues requests to instruction memory over a req/gnt + rvalid interface, honours hazard stalls, and handles branch/jump redirects.
- Buffers one response so a stall never loses an instruction; drives a NOP bubble (0x00000013) whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address, word aligned
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid (one per granted request, >=1 cycle after gnt)
imem_rdata_i  input  32  instruction word
stall_i  input  1  hazard stall; 1 = IF/ID holds, output not consumed
redirect_i  input  1  taken branch/jump, flush IF
redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced 0
if_valid_o  output  1  if_pc_o/if_instr_o hold a real instruction
if_pc_o  output  32  PC of presented instruction (0 when invalid)
if_instr_o  output  32  instruction, or 0x00000013 when invalid

Behaviour:
- Reset (rst_i=1 at edge):
  - state=IDLE, fetch_pc=RESET_PC, output and skid entries invalid.
  - if_pc_o=0, if_instr_o=0x00000013, if_valid_o=0.
  - imem_req_o=0 while in reset.
  - Reset mid-transaction: any outstanding response arriving after reset is ignored; memory side is reset together with the core.
- Interface rules:
  - imem_req_o and imem_addr_o are combinational from state and registers.
  - Once imem_req_o is asserted, it and imem_addr_o stay stable until imem_gnt_i.
  - At most one request is outstanding.
- FSM states: IDLE, REQ, WAIT, DRAIN_REQ, DRAIN.
  - IDLE: imem_req_o=0. Go to REQ when the skid is empty (or becomes empty this cycle).
  - REQ: imem_req_o=1, addr=fetch_pc. On gnt, fetch_pc += 4 (wraps 0xFFFFFFFC -> 0) and go to WAIT.
  - WAIT: on rvalid, write the response with pc=granted address: to the output register if it is empty or consumed this cycle, otherwise to the skid. Then go to REQ if the skid will be empty, else IDLE.
  - DRAIN_REQ: request is stale but still presented. Keep old address until gnt, then go to DRAIN. fetch_pc is not incremented.
  - DRAIN: discard the next rvalid, then go to REQ.
- Consumption: the output is consumed when if_valid_o=1 and stall_i=0.
  - On consumption, output <= skid if the skid is valid (skid cleared), else output becomes invalid/NOP.
  - While stall_i=1, output and skid hold unchanged.
- Redirect: highest priority, overrides stall.
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}; output and skid invalidated (NOP) next cycle.
  - From REQ: gnt same cycle -> DRAIN; no gnt -> DRAIN_REQ.
  - From WAIT: rvalid same cycle -> response dropped, go to REQ; no rvalid -> DRAIN.
  - From DRAIN_REQ/DRAIN: only fetch_pc is updated; state follows normal rules.
  - From IDLE: go to REQ.
- Latency: req+gnt in cycle N, rvalid in N+1 -> if_valid_o in N+2. Peak throughput is 1 instruction per 2 cycles.
- rvalid in IDLE or REQ is a protocol error: ignored, assertion fires.

Decomposition:
- Package if_pkg: NOP_INSTR = 32'h00000013, fetch_state_e enum, fetch_entry_t struct {valid, pc[31:0], instr[31:0]}.
- Sub-module if_out_buffer: output register plus one-entry skid, with load/consume/flush controls and a skid_full status. The FSM stays in if_fetch_unit.

Test Plan:
- Reset, then gnt same cycle, rvalid 1 cycle later -> addr 0x0,0x4,0x8 in order; if_valid_o first high 2 cycles after the first req; if_pc_o 0x0,0x4,0x8 with the matching rdata.
- stall_i held 6 cycles with memory responsive -> output holds PC 0x4, skid takes 0x8, imem_req_o=0 while the skid is full; on release 0x4 then 0x8 are presented on consecutive cycles with none lost or duplicated.
- Redirect to 0x100 during WAIT, rvalid for 0x8 next cycle -> 0x8 discarded; if_instr_o=NOP for the flush cycle; next request addr 0x100.
- Redirect to 0x203 in REQ with gnt withheld 3 cycles -> addr stays at the stale value until gnt; stale response dropped; next addr 0x200.
- Redirect to 0xFFFFFFFC -> fetch 0xFFFFFFFC, then 0x00000000 (wrap).
- rst_i asserted in WAIT -> next cycle if_valid_o=0, if_instr_o=0x00000013, if_pc_o=0; after release the first req addr is RESET_PC.
